// File: rtl/spm_arbiter.sv
// -----------------------------------------------------------------------------
// spm_arbiter
//
// Shares the single-port scratchpad memory between the instruction-fetch port
// (IF, read-only) and the mem_stage data port (MEM). One requester is granted
// per cycle. Its address, strobe, read/write and write data go to the SPM, and
// the other requester is stalled through its busy output. Read data, which the
// SPM returns one cycle after the strobe, is routed back to the port that
// issued the read. A starvation counter lets IF win one arbitration after
// STARVE_MAX consecutive denials, so fetch keeps making progress when MEM
// traffic is continuous.
//
// Configuration macro: SPM_ARB_PERF_EN
//   When defined, adds the perf_clr input and the perf_conflict and
//   perf_if_starve counters. When undefined, those ports do not exist and
//   arbitration behaves the same.
//
// Ports
//   clk            clock
//   reset          asynchronous reset, active-low (0 = reset)
//   if_addr        IF word address
//   if_as_         IF address strobe, active-low
//   if_rd_data     IF read data, zero unless if_rd_vld
//   if_rd_vld      IF read data valid
//   if_busy        IF stall (requesting but not granted)
//   mem_addr       MEM word address
//   mem_as_        MEM address strobe, active-low
//   mem_rw         MEM direction, 1 = read, 0 = write
//   mem_wr_data    MEM write data
//   mem_rd_data    MEM read data, zero unless mem_rd_vld
//   mem_rd_vld     MEM read data valid
//   mem_busy       MEM stall (requesting but not granted)
//   spm_addr       SPM address
//   spm_as_        SPM address strobe, active-low
//   spm_rw         SPM direction, 1 = read, 0 = write
//   spm_wr_data    SPM write data
//   spm_rd_data    SPM read data, valid one cycle after a read strobe
//   perf_clr       (SPM_ARB_PERF_EN) synchronous clear of the perf counters
//   perf_conflict  (SPM_ARB_PERF_EN) cycles in which both ports requested
//   perf_if_starve (SPM_ARB_PERF_EN) cycles in which IF won by starvation
// -----------------------------------------------------------------------------
module spm_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_as_,
    output logic [DATA_W-1:0] if_rd_data,
    output logic              if_rd_vld,
    output logic              if_busy,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_as_,
    input  logic              mem_rw,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd_vld,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
`ifdef SPM_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_if_starve
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } rd_own_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic       RW_READ    = 1'b1;

    logic [3:0] starve_cnt;
    rd_own_t    rd_own;
    logic       if_req;
    logic       mem_req;
    logic       starve_hit;
    logic       grant_if;
    logic       grant_mem;

    // Requests are masked while reset is held, so the SPM strobe and both
    // busy outputs stay inactive whatever the requesters drive.
    assign if_req     = reset & ~if_as_;
    assign mem_req    = reset & ~mem_as_;
    assign starve_hit = (starve_cnt >= STARVE_LIM);

    // MEM has priority on a conflict unless IF has already been denied
    // STARVE_MAX times in a row.
    assign grant_if  = if_req & (~mem_req | starve_hit);
    assign grant_mem = mem_req & ~grant_if;

    assign if_busy  = if_req & ~grant_if;
    assign mem_busy = mem_req & ~grant_mem;

    // Forward the granted port to the SPM. IF is read-only and has no write
    // data. An idle SPM sees a parked read with zero address and data.
    always_comb begin
        spm_as_     = 1'b1;
        spm_addr    = '0;
        spm_rw      = RW_READ;
        spm_wr_data = '0;
        if (grant_if) begin
            spm_as_  = 1'b0;
            spm_addr = if_addr;
        end else if (grant_mem) begin
            spm_as_     = 1'b0;
            spm_addr    = mem_addr;
            spm_rw      = mem_rw;
            spm_wr_data = mem_wr_data;
        end
    end

    // Starvation tracking and read-return ownership. rd_own records which
    // port issued the read in flight, so the next cycle's SPM data goes back
    // to that port. Writes and idle cycles leave nothing in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            rd_own     <= OWN_NONE;
        end else begin
            if (!if_req || grant_if) begin
                starve_cnt <= '0;
            end else if (starve_cnt < STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            if (grant_if) begin
                rd_own <= OWN_IF;
            end else if (grant_mem && (mem_rw == RW_READ)) begin
                rd_own <= OWN_MEM;
            end else begin
                rd_own <= OWN_NONE;
            end
        end
    end

    assign if_rd_vld   = (rd_own == OWN_IF);
    assign mem_rd_vld  = (rd_own == OWN_MEM);
    assign if_rd_data  = if_rd_vld  ? spm_rd_data : '0;
    assign mem_rd_data = mem_rd_vld ? spm_rd_data : '0;

`ifdef SPM_ARB_PERF_EN
    // Free-running event counters. They wrap naturally at 2^32, and a clear
    // takes priority over a count in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_conflict  <= '0;
            perf_if_starve <= '0;
        end else if (perf_clr) begin
            perf_conflict  <= '0;
            perf_if_starve <= '0;
        end else begin
            if (if_req && mem_req) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            if (if_req && mem_req && starve_hit) begin
                perf_if_starve <= perf_if_starve + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spm_arbiter
//
// Self-checking bench for spm_arbiter. A small SPM model answers the arbiter.
// A reference model tracks IF denials, the single read in flight and the perf
// counts, and it predicts every arbiter output for each cycle. Directed
// scenarios run first, followed by randomized traffic in which a busy
// requester keeps its request, or sometimes withdraws it.
// -----------------------------------------------------------------------------
module tb_spm_arbiter;

    localparam int ADDR_W     = 30;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_as_ = 1'b1;
    logic [DATA_W-1:0] if_rd_data;
    logic              if_rd_vld;
    logic              if_busy;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic              mem_as_ = 1'b1;
    logic              mem_rw = 1'b1;
    logic [DATA_W-1:0] mem_wr_data = '0;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_vld;
    logic              mem_busy;
    logic [ADDR_W-1:0] spm_addr;
    logic              spm_as_;
    logic              spm_rw;
    logic [DATA_W-1:0] spm_wr_data;
    logic [DATA_W-1:0] spm_rd_data;
`ifdef SPM_ARB_PERF_EN
    logic              perf_clr = 1'b0;
    logic [31:0]       perf_conflict;
    logic [31:0]       perf_if_starve;
`endif

    int num_checks = 0;
    int num_errors = 0;

    // Reference model state
    int          wait_cnt      = 0;
    int          pend_owner    = 0;
    logic [31:0] pend_data     = '0;
    int unsigned m_conflict    = 0;
    int unsigned m_starve      = 0;
    logic        last_if_busy  = 1'b0;
    logic        last_mem_busy = 1'b0;
    int          last_winner   = 0;

    // SPM contents, loaded once while reset is held
    logic [31:0] mem [256];
    logic        preload_done = 1'b0;

    spm_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_addr    (if_addr),
        .if_as_     (if_as_),
        .if_rd_data (if_rd_data),
        .if_rd_vld  (if_rd_vld),
        .if_busy    (if_busy),
        .mem_addr   (mem_addr),
        .mem_as_    (mem_as_),
        .mem_rw     (mem_rw),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .mem_rd_vld (mem_rd_vld),
        .mem_busy   (mem_busy),
        .spm_addr   (spm_addr),
        .spm_as_    (spm_as_),
        .spm_rw     (spm_rw),
        .spm_wr_data(spm_wr_data),
        .spm_rd_data(spm_rd_data)
`ifdef SPM_ARB_PERF_EN
        ,
        .perf_clr      (perf_clr),
        .perf_conflict (perf_conflict),
        .perf_if_starve(perf_if_starve)
`endif
    );

    always #5 clk = ~clk;

    // SPM model. A read returns data on the following edge. Cycles with no
    // read present garbage, so stale data cannot look correct.
    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h01000193 + 32'h00001111);
            end
            preload_done <= 1'b1;
        end
        if (!spm_as_ && spm_rw) begin
            spm_rd_data <= mem[spm_addr[7:0]];
        end else begin
            spm_rd_data <= $urandom;
        end
        if (!spm_as_ && !spm_rw) begin
            mem[spm_addr[7:0]] <= spm_wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one cycle of requests, predicts and checks every output, then
    // advances the reference model past the coming clock edge.
    task automatic applyStimulus(input logic ias, input logic [ADDR_W-1:0] iaddr,
                                 input logic mas, input logic mrw,
                                 input logic [ADDR_W-1:0] maddr, input logic [31:0] mdata,
                                 input logic clr);
        logic ireq, mreq;
        int   winner;
        logic [31:0] e_addr, e_wdata;
        logic e_rw;
        @(negedge clk);
        if_as_      = ias;
        if_addr     = iaddr;
        mem_as_     = mas;
        mem_rw      = mrw;
        mem_addr    = maddr;
        mem_wr_data = mdata;
`ifdef SPM_ARB_PERF_EN
        perf_clr    = clr;
`endif
        #1;
        ireq = !ias;
        mreq = !mas;
        if (ireq && (!mreq || wait_cnt >= STARVE_MAX)) winner = 1;
        else if (mreq) winner = 2;
        else winner = 0;

        e_addr  = (winner == 1) ? 32'(iaddr) : (winner == 2) ? 32'(maddr) : 32'd0;
        e_rw    = (winner == 2) ? mrw : 1'b1;
        e_wdata = (winner == 2) ? mdata : 32'd0;

        checkOutput("spm_as_",     32'(spm_as_),     32'(winner == 0));
        checkOutput("spm_addr",    32'(spm_addr),    e_addr);
        checkOutput("spm_rw",      32'(spm_rw),      32'(e_rw));
        checkOutput("spm_wr_data", spm_wr_data,      e_wdata);
        checkOutput("if_busy",     32'(if_busy),     32'(ireq && winner != 1));
        checkOutput("mem_busy",    32'(mem_busy),    32'(mreq && winner != 2));
        checkOutput("if_rd_vld",   32'(if_rd_vld),   32'(pend_owner == 1));
        checkOutput("if_rd_data",  if_rd_data,       (pend_owner == 1) ? pend_data : 32'd0);
        checkOutput("mem_rd_vld",  32'(mem_rd_vld),  32'(pend_owner == 2));
        checkOutput("mem_rd_data", mem_rd_data,      (pend_owner == 2) ? pend_data : 32'd0);
        checkOutput("both_vld",    32'(if_rd_vld & mem_rd_vld), 32'd0);
`ifdef SPM_ARB_PERF_EN
        checkOutput("perf_conflict",  perf_conflict,  m_conflict);
        checkOutput("perf_if_starve", perf_if_starve, m_starve);
        if (clr) begin
            m_conflict = 0;
            m_starve   = 0;
        end else begin
            if (ireq && mreq) m_conflict++;
            if (ireq && mreq && winner == 1) m_starve++;
        end
`endif

        if (ireq && winner != 1) wait_cnt = (wait_cnt < STARVE_MAX) ? wait_cnt + 1 : wait_cnt;
        else wait_cnt = 0;

        if (winner == 1) begin
            pend_owner = 1;
            pend_data  = mem[iaddr[7:0]];
        end else if (winner == 2 && mrw) begin
            pend_owner = 2;
            pend_data  = mem[maddr[7:0]];
        end else begin
            pend_owner = 0;
        end
        last_if_busy  = ireq && winner != 1;
        last_mem_busy = mreq && winner != 2;
        last_winner   = winner;
    endtask

    // Checks that reset masks active requests and then releases reset with
    // both strobes idle. The model's state returns to its reset values.
    task automatic checkResetHeld(input string tag);
        checkOutput({tag, "_spm_as_"},    32'(spm_as_),    32'd1);
        checkOutput({tag, "_if_busy"},    32'(if_busy),    32'd0);
        checkOutput({tag, "_mem_busy"},   32'(mem_busy),   32'd0);
        checkOutput({tag, "_if_vld"},     32'(if_rd_vld),  32'd0);
        checkOutput({tag, "_mem_vld"},    32'(mem_rd_vld), 32'd0);
        checkOutput({tag, "_if_data"},    if_rd_data,      32'd0);
        checkOutput({tag, "_mem_data"},   mem_rd_data,     32'd0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        if_as_  = 1'b1;
        mem_as_ = 1'b1;
        reset   = 1'b1;
        wait_cnt   = 0;
        pend_owner = 0;
        m_conflict = 0;
        m_starve   = 0;
    endtask

    initial begin
        logic        ias, mas, mrw;
        logic [29:0] iaddr, maddr;
        logic [31:0] mdata;
        int          if_grants;

        // Reset with both ports requesting
        reset   = 1'b0;
        if_as_  = 1'b0;
        mem_as_ = 1'b0;
        mem_rw  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkResetHeld("rst");
        releaseReset();

        // IF read alone at 0x10, then an idle cycle that shows the return
        applyStimulus(1'b0, 30'h10, 1'b1, 1'b1, 30'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 30'h0,  1'b1, 1'b1, 30'h0, 32'h0, 1'b0);
        checkOutput("t1_if_data", if_rd_data, 32'hDEADBEEF);

        // Both request and MEM writes 0x1234 to 0x20
        applyStimulus(1'b0, 30'h11, 1'b0, 1'b0, 30'h20, 32'h1234, 1'b0);
        applyStimulus(1'b1, 30'h0,  1'b1, 1'b1, 30'h0,  32'h0,    1'b0);
        checkOutput("t2_no_vld", 32'(if_rd_vld | mem_rd_vld), 32'd0);

        // IF read at t, MEM read of the written word at t+1
        applyStimulus(1'b0, 30'h30, 1'b1, 1'b1, 30'h0,  32'h0, 1'b0);
        applyStimulus(1'b1, 30'h0,  1'b0, 1'b1, 30'h20, 32'h0, 1'b0);
        applyStimulus(1'b1, 30'h0,  1'b1, 1'b1, 30'h0,  32'h0, 1'b0);
        checkOutput("t4_mem_data", mem_rd_data, 32'h1234);
        applyStimulus(1'b1, 30'h0,  1'b1, 1'b1, 30'h0,  32'h0, 1'b0);

        // Both held for 8 cycles: IF wins one arbitration in four
        if_grants = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 30'h40, 1'b0, 1'b1, 30'h50, 32'h0, 1'b0);
            if (spm_addr == 30'h40) if_grants++;
        end
        checkOutput("t3_if_grants", 32'(if_grants), 32'd2);
        applyStimulus(1'b1, 30'h0, 1'b1, 1'b1, 30'h0, 32'h0, 1'b0);

        // Reset asserted right after a MEM read has been captured
        applyStimulus(1'b0, 30'h60, 1'b0, 1'b1, 30'h61, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkResetHeld("t5a");
        @(posedge clk);
        #1;
        checkResetHeld("t5b");
        releaseReset();
        applyStimulus(1'b1, 30'h0,  1'b0, 1'b1, 30'h62, 32'h0, 1'b0);
        applyStimulus(1'b1, 30'h0,  1'b1, 1'b1, 30'h0,  32'h0, 1'b0);
        checkOutput("t5_fresh_vld", 32'(mem_rd_vld), 32'd1);

        // Conflicts right after reset show the starvation count starting at zero
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 30'h70, 1'b0, 1'b0, 30'h71, 32'h5555, 1'b0);
        end
        checkOutput("t5_starve_win", 32'(last_winner), 32'd1);

`ifdef SPM_ARB_PERF_EN
        // Clear the counters, then run 10 conflict cycles
        applyStimulus(1'b1, 30'h0, 1'b1, 1'b1, 30'h0, 32'h0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 30'h72, 1'b0, 1'b1, 30'h73, 32'h0, 1'b0);
        end
        applyStimulus(1'b1, 30'h0, 1'b1, 1'b1, 30'h0, 32'h0, 1'b1);
        checkOutput("t6_conflict", perf_conflict,  32'd10);
        checkOutput("t6_starve",   perf_if_starve, 32'd2);
        applyStimulus(1'b1, 30'h0, 1'b1, 1'b1, 30'h0, 32'h0, 1'b0);
        checkOutput("t6_clr_conflict", perf_conflict,  32'd0);
        checkOutput("t6_clr_starve",   perf_if_starve, 32'd0);
`endif

        // Randomized traffic. A busy requester usually keeps its request.
        ias = 1'b1; mas = 1'b1; mrw = 1'b1;
        iaddr = '0; maddr = '0; mdata = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(last_if_busy && $urandom_range(0, 9) != 0)) begin
                ias   = ($urandom_range(0, 3) == 0);
                iaddr = 30'($urandom_range(0, 255));
            end
            if (!(last_mem_busy && $urandom_range(0, 9) != 0)) begin
                mas   = ($urandom_range(0, 3) == 0);
                mrw   = $urandom_range(0, 1) == 1;
                maddr = 30'($urandom_range(0, 255));
                mdata = $urandom;
            end
            applyStimulus(ias, iaddr, mas, mrw, maddr, mdata, ($urandom_range(0, 63) == 0));
        end
        applyStimulus(1'b1, 30'h0, 1'b1, 1'b1, 30'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
